// File: rtl/spi_slave_regfile.sv
// SPI slave command endpoint: deserialises 41-bit frames {wr_rd_en, chip_sel, addr[6:0], data[31:0]}
// and executes them against a local 128 x 32-bit register file, returning read data on MISO in-frame.
module spi_slave_regfile #(
    parameter logic SLAVE_ID = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        wr_strobe,
    output logic [6:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_WAIT_CS = 2'd3
    } state_t;

    logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic        cs_s1_q, cs_s2_q, cs_s3_q;
    logic        mosi_s1_q, mosi_s2_q;

    state_t      state_q, state_d;
    logic [5:0]  bcnt_q, bcnt_d;
    logic [31:0] sr_q, sr_d;
    logic [6:0]  addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic        mem_we_s;
    logic [31:0] mem_q [128];

    logic        sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
    logic [31:0] shifted_s;
    logic [31:0] rd_word_s;
    logic [4:0]  bit_idx_s;

    // Synchronisers; cs_n chain resets low so a chip select already held low at reset release is not seen as a new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cs_s3_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= spi_clk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= spi_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign sclk_rise_s = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall_s = ~sclk_s2_q & sclk_s3_q;
    assign cs_rise_s   = cs_s2_q & ~cs_s3_q;
    assign cs_fall_s   = ~cs_s2_q & cs_s3_q;
    assign shifted_s   = {sr_q[30:0], mosi_s2_q};
    assign rd_word_s   = mem_q[addr_q];
    // 40 - bcnt taken modulo 32; exact for bcnt in 9..40
    assign bit_idx_s   = 5'd8 - bcnt_q[4:0];

    // Frame FSM next-state and output decode
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d = ST_SHIFT;
                    bcnt_d  = 6'd0;
                    sr_d    = 32'd0;
                    addr_d  = 7'd0;
                    rd_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    if (bcnt_q == 6'd40) begin
                        sr_d    = shifted_s;
                        state_d = ST_COMMIT;
                    end else begin
                        state_d     = ST_IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_fall_s) begin
                    sr_d   = shifted_s;
                    bcnt_d = bcnt_q + 6'd1;
                    if (bcnt_q == 6'd40) begin
                        state_d = ST_COMMIT;
                    end else if (bcnt_q == 6'd8) begin
                        if (shifted_s[7] != SLAVE_ID) begin
                            state_d     = ST_WAIT_CS;
                            frame_err_d = 1'b1;
                        end else begin
                            addr_d = shifted_s[6:0];
                            rd_d   = ~shifted_s[8];
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else if (sclk_rise_s && rd_q && (bcnt_q >= 6'd9) && (bcnt_q <= 6'd40)) begin
                    miso_d = rd_word_s[bit_idx_s];
                    oe_d   = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                if (!rd_q) begin
                    mem_we_s    = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = sr_q;
                end else begin
                    mem_we_s = 1'b0;
                end
                state_d = cs_s2_q ? ST_IDLE : ST_WAIT_CS;
            end
            ST_WAIT_CS: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_CS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != ST_SHIFT) begin
            oe_d   = 1'b0;
            miso_d = 1'b0;
        end else begin
            oe_d = oe_d;
        end
    end

    // Frame FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bcnt_q      <= 6'd0;
            sr_q        <= 32'd0;
            addr_q      <= 7'd0;
            rd_q        <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 32'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Register file, written at the end of the commit cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_we_s) begin
            mem_q[addr_q] <= sr_q;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: a bit-banged SPI master drives frames, a monitor counts
// strobe/error pulses, and each expectation is a hand-computed constant.
module tb_spi_slave_regfile;

    localparam int H = 5;

    logic        clk;
    logic        rst;
    logic        spi_clk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;

    int          strobe_cnt  = 0;
    int          ferr_cnt    = 0;
    int          overlap_cnt = 0;
    int          wide_cnt    = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_ferr   = 1'b0;
    logic [6:0]  last_addr   = 7'd0;
    logic [31:0] last_data   = 32'd0;

    logic [40:0] miso_samp;
    logic [40:0] oe_samp;

    spi_slave_regfile #(.SLAVE_ID(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            last_addr  = wr_addr;
            last_data  = wr_data;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (wr_strobe && frame_err) overlap_cnt = overlap_cnt + 1;
        if ((wr_strobe && prev_strobe) || (frame_err && prev_ferr)) wide_cnt = wide_cnt + 1;
        prev_strobe = wr_strobe;
        prev_ferr   = frame_err;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] build(input logic wr, input logic id, input logic [6:0] a,
                                          input logic [31:0] d);
        return {wr, id, a, d};
    endfunction

    // cs_mode on the last bit: 0 none, 1 cs_n up with the falling edge, 2 one clk early, 3 one clk late
    task automatic send_bit(input int idx, input logic b, input int cs_mode);
        spi_clk  = 1'b1;
        spi_mosi = b;
        repeat (H - 1) @(negedge clk);
        if (cs_mode == 2) spi_cs_n = 1'b1;
        @(negedge clk);
        miso_samp[idx] = spi_miso;
        oe_samp[idx]   = spi_miso_oe;
        spi_clk = 1'b0;
        if (cs_mode == 1) spi_cs_n = 1'b1;
        @(negedge clk);
        if (cs_mode == 3) spi_cs_n = 1'b1;
        repeat (H - 1) @(negedge clk);
    endtask

    task automatic cs_start();
        miso_samp = '0;
        oe_samp   = '0;
        spi_cs_n  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [40:0] f, input int end_mode);
        cs_start();
        for (int i = 0; i < 41; i++) begin
            send_bit(i, f[40 - i], (i == 40) ? end_mode : 0);
        end
        cs_end();
    endtask

    task automatic do_read(input logic [6:0] a, output logic [31:0] d);
        send_frame(build(1'b0, 1'b0, a, 32'h0000_0000), 0);
        for (int k = 0; k < 32; k++) begin
            d[31 - k] = miso_samp[9 + k];
        end
    endtask

    initial begin
        logic [31:0] rdata;
        logic [40:0] f;
        int          s0;
        int          e0;

        rst      = 1'b1;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_miso", 64'(spi_miso), 64'h0);
        chk("rst_oe", 64'(spi_miso_oe), 64'h0);
        chk("rst_wr_strobe", 64'(wr_strobe), 64'h0);
        chk("rst_wr_addr", 64'(wr_addr), 64'h0);
        chk("rst_wr_data", 64'(wr_data), 64'h0);
        chk("rst_frame_err", 64'(frame_err), 64'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Basic write
        send_frame(build(1'b1, 1'b0, 7'h05, 32'hDEAD_BEEF), 0);
        chk("wr05_strobes", 64'(strobe_cnt), 64'd1);
        chk("wr05_addr", 64'(last_addr), 64'h05);
        chk("wr05_data", 64'(last_data), 64'hDEAD_BEEF);
        chk("wr05_ferr", 64'(ferr_cnt), 64'd0);
        chk("wr05_oe", 64'(oe_samp), 64'h0);
        chk("wr05_port_addr", 64'(wr_addr), 64'h05);

        // Read back, with output-enable window
        do_read(7'h05, rdata);
        chk("rd05_data", 64'(rdata), 64'hDEAD_BEEF);
        chk("rd05_oe_window", 64'(oe_samp), 64'h1FF_FFFF_FE00);
        chk("rd05_no_strobe", 64'(strobe_cnt), 64'd1);
        do_read(7'h7F, rdata);
        chk("rd7f_data", 64'(rdata), 64'h0);
        chk("rd7f_ferr", 64'(ferr_cnt), 64'd0);

        // Wrong chip_sel
        send_frame(build(1'b1, 1'b1, 7'h05, 32'h1234_5678), 0);
        chk("idmis_ferr", 64'(ferr_cnt), 64'd1);
        chk("idmis_strobe", 64'(strobe_cnt), 64'd1);
        chk("idmis_oe", 64'(oe_samp), 64'h0);
        do_read(7'h05, rdata);
        chk("idmis_rd05", 64'(rdata), 64'hDEAD_BEEF);

        // Aborted write after 20 bits
        f = build(1'b1, 1'b0, 7'h10, 32'hCAFE_F00D);
        cs_start();
        for (int i = 0; i < 20; i++) begin
            send_bit(i, f[40 - i], 0);
        end
        cs_end();
        chk("abort_ferr", 64'(ferr_cnt), 64'd2);
        chk("abort_strobe", 64'(strobe_cnt), 64'd1);
        do_read(7'h10, rdata);
        chk("abort_rd10", 64'(rdata), 64'h0);

        // cs_n raised around the last falling edge
        send_frame(build(1'b1, 1'b0, 7'h31, 32'h1357_9BDF), 1);
        chk("cs_coinc_strobe", 64'(strobe_cnt), 64'd2);
        chk("cs_coinc_data", 64'(last_data), 64'h1357_9BDF);
        send_frame(build(1'b1, 1'b0, 7'h32, 32'h2468_ACE1), 2);
        chk("cs_early_strobe", 64'(strobe_cnt), 64'd3);
        chk("cs_early_data", 64'(last_data), 64'h2468_ACE1);
        send_frame(build(1'b1, 1'b0, 7'h33, 32'h8000_0001), 3);
        chk("cs_late_strobe", 64'(strobe_cnt), 64'd4);
        chk("cs_late_addr", 64'(last_addr), 64'h33);
        chk("cs_late_data", 64'(last_data), 64'h8000_0001);
        chk("cs_skew_ferr", 64'(ferr_cnt), 64'd2);
        do_read(7'h32, rdata);
        chk("cs_early_rd32", 64'(rdata), 64'h2468_ACE1);

        // Reset in the middle of a write, cs_n held low
        s0 = strobe_cnt;
        e0 = ferr_cnt;
        f  = build(1'b1, 1'b0, 7'h22, 32'h55AA_55AA);
        cs_start();
        for (int i = 0; i < 30; i++) begin
            send_bit(i, f[40 - i], 0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_wr_addr", 64'(wr_addr), 64'h0);
        chk("midrst_wr_data", 64'(wr_data), 64'h0);
        chk("midrst_oe", 64'(spi_miso_oe), 64'h0);
        chk("midrst_miso", 64'(spi_miso), 64'h0);
        chk("midrst_strobe", 64'(wr_strobe), 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 30; i < 41; i++) begin
            send_bit(i, f[40 - i], 0);
        end
        cs_end();
        chk("midrst_no_commit", 64'(strobe_cnt - s0), 64'd0);
        chk("midrst_no_ferr", 64'(ferr_cnt - e0), 64'd0);
        do_read(7'h22, rdata);
        chk("midrst_rd22", 64'(rdata), 64'h0);
        do_read(7'h05, rdata);
        chk("midrst_rd05_cleared", 64'(rdata), 64'h0);
        send_frame(build(1'b1, 1'b0, 7'h22, 32'h0F0F_0F0F), 0);
        chk("post_rst_strobe", 64'(strobe_cnt - s0), 64'd1);
        chk("post_rst_data", 64'(last_data), 64'h0F0F_0F0F);
        do_read(7'h22, rdata);
        chk("post_rst_rd22", 64'(rdata), 64'h0F0F_0F0F);

        chk("no_strobe_err_overlap", 64'(overlap_cnt), 64'd0);
        chk("pulse_width_one", 64'(wide_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

SPI slave endpoint that terminates one chip-select line of the bridge's SPI master. It deserialises 41-bit command frames and executes them against a local 128 x 32-bit register file. A write frame updates a register. A read frame returns register contents on MISO in the same frame, and the master pushes that data into its RX FIFO. Two instances, with SLAVE_ID 0 and 1, sit on spi_cs0/spi_cs1 and share one MISO through spi_miso_oe.

## Interface
- SLAVE_ID, 1'b0: frame bit 39 value this instance accepts.
- clk  in  1  system clock, oversamples all SPI inputs.
- rst  in  1  reset rst, asynchronous, active-high; clock clk.
- spi_clk  in  1  SPI clock from master, idle low, asynchronous to clk.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data from master, MSB (frame bit 40) first.
- spi_miso  out  1  serial read data to master.
- spi_miso_oe  out  1  high while this slave drives read data; top level muxes MISO on it.
- wr_strobe  out  1  one-cycle pulse when a write commits.
- wr_addr  out  7  address of the committed write.
- wr_data  out  32  data of the committed write.
- frame_err  out  1  one-cycle pulse when a frame is aborted or rejected.

## Operation
- Frame format, 41 bits, MSB first: [40] wr_rd_en (1 = write, 0 = read), [39] chip_sel, [38:32] addr, [31:0] data. For reads, the data field on MOSI is don't-care.
- Input conditioning: spi_clk, spi_cs_n and spi_mosi each pass through a 2-flop synchroniser. Edges of spi_clk and spi_cs_n are detected from the last two synchronised samples.
- MOSI is sampled on each detected spi_clk falling edge (mid-bit; the master changes MOSI only at rising edges).
- A 6-bit bit counter (bcnt) counts captured bits.
- States:
  - IDLE: spi_cs_n high. Synchronised cs_n falling edge -> SHIFT, bcnt=0, shift register cleared.
  - SHIFT: capture one bit per falling edge.
    - When bcnt reaches 9 (header complete): if bit 39 != SLAVE_ID -> WAIT_CS with frame_err pulse. Otherwise latch addr and wr_rd_en.
    - The frame is complete on the 41st falling edge. It is also complete on a cs_n rising edge with bcnt==40; bit 0 is then taken from the current synchronised MOSI. This covers the master raising cs_n on the last falling edge, with either ordering skew.
    - On completion -> COMMIT.
    - A cs_n rising edge with bcnt<40 -> IDLE with frame_err pulse; no register change.
  - COMMIT, one cycle: on a write, mem[addr] <= data and wr_strobe=1 with wr_addr/wr_data. On a read, nothing happens. Then -> WAIT_CS if cs_n is still low, else IDLE.
  - WAIT_CS: ignore further spi_clk edges. cs_n rising -> IDLE.
- Read data path:
  - On a read frame with matching ID, on each detected spi_clk rising edge with bcnt in 9..40, spi_miso <= mem[addr][40-bcnt] and spi_miso_oe=1.
  - The master samples at the following falling edge, so frame bit 9 carries data[31] and bit 40 carries data[0].
  - spi_miso_oe drops on leaving SHIFT.
- The register file is not bypassed: a read of the address being written in the same frame cannot occur, since there is one command per frame.
- Reset values: all 128 registers 0, state IDLE, spi_miso 0, spi_miso_oe 0, wr_strobe 0, wr_addr 0, wr_data 0, frame_err 0.
- rst mid-frame returns the block to IDLE immediately. If cs_n is still low when rst releases, the block does not enter SHIFT until a fresh cs_n falling edge, so the partial frame is discarded.

## Timing
- Input-to-detect latency is 3 clk (2 synchroniser stages + 1 edge register).
- Requirement: each spi_clk high and low phase is at least 4 clk periods, i.e. f_clk >= 8 x f_spi_clk.
- spi_miso updates exactly 3 clk after the spi_clk rising edge. That is at least 1 clk before the master's next sampling edge.
- Commit latency: wr_strobe asserts 1 clk after completion detection, which is at most 4 clk after the last spi_clk falling edge. mem is updated at that same clk edge.
- wr_strobe and frame_err are exactly one clk wide and never assert in the same cycle.
- Back-to-back frames: the cs_n high gap must be at least 4 clk to be detected.

## Test plan
- Write 0x05 = 0xDEADBEEF with SLAVE_ID=0 -> one wr_strobe, wr_addr=0x05, wr_data=0xDEADBEEF, frame_err stays 0.
- Read 0x05 after that write -> MISO bits 9..40 equal 0xDEADBEEF MSB first, spi_miso_oe high only during those bits. Read 0x7F -> returns 0x00000000.
- Frame with bit 39=1 to the SLAVE_ID=0 instance -> frame_err pulse at bit 9, spi_miso_oe stays 0, no register change, and a later read of the target address returns its old value.
- cs_n raised after 20 bits of a write to 0x10 -> frame_err pulse, no wr_strobe, and a read of 0x10 returns 0.
- cs_n raised coincident with the 41st falling edge, and also 1 clk early/late -> the write commits with correct bit 0 in all three cases.
- rst asserted at bit 30 of a write to 0x22 with cs_n held low -> outputs at reset values, and no commit when the remaining bits arrive. The next complete frame then executes normally.
